mem_stage_ctrl: RTL and testbench

//  Memory-stage access controller between the EX/MEM and MEM/WB pipeline registers.
//  - Issues loads/stores from EX/MEM to a variable-latency data memory.
//  - Holds the pipeline (stall_o) while the access is outstanding.
//  - Presents read data and a completion valid to MEM/WB.
//  - Flags unaligned, conflicting or timed-out accesses as a sticky error.

---
 rtl/mem_stage_ctrl.sv | 133 +++++++++++++
 tb/tb_mem_stage_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// Memory-stage access controller: issues EX/MEM loads/stores to a variable-latency
// data memory, stalls the pipeline while outstanding, and flags faults as a sticky error.
module mem_stage_ctrl #(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_i,
   input  logic              Mem_read,
   input  logic              Mem_write,
   input  logic [DATA_W-1:0] address,
   input  logic [DATA_W-1:0] write_data,
   input  logic              mem_busy,
   input  logic              mem_done,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] data_read,
   output logic              valid_o,
   output logic              stall_o,
   output logic              err_o
);

   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ERR  = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [DATA_W-1:0] r_lat_addr;
   logic [DATA_W-1:0] r_lat_wdata;
   logic              r_lat_wr;
   logic [CNT_W-1:0]  r_wait_cnt;
   logic [CNT_W-1:0]  w_wait_cnt_nxt;
   logic              w_acc;
   logic              w_bad;
   logic              w_latch;

   assign w_acc = valid_i & (Mem_read | Mem_write);
   assign w_bad = (Mem_read & Mem_write) | address[0];

   // State, timeout counter and latched request
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_wait_cnt  <= '0;
         r_lat_addr  <= '0;
         r_lat_wdata <= '0;
         r_lat_wr    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_cnt_nxt;
         if (w_latch) begin
            r_lat_addr  <= address;
            r_lat_wdata <= write_data;
            r_lat_wr    <= Mem_write;
         end
      end
   end

   // Next state and combinational outputs; requests go out in the same cycle as EX/MEM presents them
   always_comb begin
      w_state_nxt    = r_state;
      w_wait_cnt_nxt = r_wait_cnt;
      w_latch        = 1'b0;
      mem_rd         = 1'b0;
      mem_wr         = 1'b0;
      mem_addr       = '0;
      mem_wdata      = '0;
      data_read      = '0;
      valid_o        = 1'b0;
      stall_o        = 1'b0;
      err_o          = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (valid_i && !w_acc) begin
               valid_o = 1'b1;
            end else if (w_acc && w_bad) begin
               stall_o     = 1'b1;
               w_state_nxt = S_ERR;
            end else if (w_acc && mem_busy) begin
               stall_o = 1'b1;
            end else if (w_acc) begin
               mem_rd    = Mem_read;
               mem_wr    = Mem_write;
               mem_addr  = address;
               mem_wdata = write_data;
               w_latch   = 1'b1;
               if (mem_done) begin
                  valid_o   = 1'b1;
                  data_read = Mem_write ? '0 : mem_rdata;
               end else begin
                  stall_o        = 1'b1;
                  w_wait_cnt_nxt = '0;
                  w_state_nxt    = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            mem_addr  = r_lat_addr;
            mem_wdata = r_lat_wdata;
            if (mem_done) begin
               valid_o     = 1'b1;
               data_read   = r_lat_wr ? '0 : mem_rdata;
               w_state_nxt = S_IDLE;
            end else begin
               stall_o = 1'b1;
               if (r_wait_cnt == CNT_LAST) begin
                  w_state_nxt = S_ERR;
               end else begin
                  w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
               end
            end
         end
         S_ERR: begin
            err_o   = 1'b1;
            stall_o = 1'b1;
         end
         default: begin
            w_state_nxt = S_ERR;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Randomised self-checking bench for mem_stage_ctrl against a transaction-level model,
// with directed scenarios pinned by literal expectations.
module tb_mem_stage_ctrl;

   localparam int unsigned DW = 16;
   localparam int unsigned TO = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          valid_i = 1'b0, Mem_read = 1'b0, Mem_write = 1'b0;
   logic [DW-1:0] address = '0, write_data = '0, mem_rdata = '0;
   logic          mem_busy = 1'b0, mem_done = 1'b0;
   logic          mem_rd, mem_wr, valid_o, stall_o, err_o;
   logic [DW-1:0] mem_addr, mem_wdata, data_read;

   always #5 clk = ~clk;

   mem_stage_ctrl #(.DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .Mem_read(Mem_read), .Mem_write(Mem_write),
      .address(address), .write_data(write_data), .mem_busy(mem_busy), .mem_done(mem_done),
      .mem_rdata(mem_rdata), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .data_read(data_read), .valid_o(valid_o), .stall_o(stall_o),
      .err_o(err_o)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   // Model: a faulted flag, and an optional outstanding transaction with its age
   bit            m_faulted;
   bit            m_pending;
   int            m_age;
   logic [DW-1:0] m_addr, m_wdata;
   bit            m_is_store;

   logic          e_rd, e_wr, e_valid, e_stall, e_err;
   logic [DW-1:0] e_addr, e_wdata, e_data;

   function automatic void model_reset();
      m_faulted = 0; m_pending = 0; m_age = 0;
      m_addr = '0; m_wdata = '0; m_is_store = 0;
   endfunction

   function automatic bit wants_access();
      return valid_i && (Mem_read || Mem_write);
   endfunction

   function automatic bit illegal();
      return (Mem_read && Mem_write) || address[0];
   endfunction

   function automatic void model_outputs();
      e_rd = 0; e_wr = 0; e_valid = 0; e_stall = 0; e_err = 0;
      e_addr = '0; e_wdata = '0; e_data = '0;
      if (!rst) return;
      if (m_faulted) begin
         e_err = 1; e_stall = 1;
      end else if (m_pending) begin
         e_addr = m_addr; e_wdata = m_wdata;
         if (mem_done) begin
            e_valid = 1;
            e_data  = m_is_store ? '0 : mem_rdata;
         end else e_stall = 1;
      end else if (valid_i && !wants_access()) begin
         e_valid = 1;
      end else if (wants_access()) begin
         if (illegal() || mem_busy) e_stall = 1;
         else begin
            e_rd = Mem_read; e_wr = Mem_write; e_addr = address; e_wdata = write_data;
            if (mem_done) begin
               e_valid = 1;
               e_data  = Mem_write ? '0 : mem_rdata;
            end else e_stall = 1;
         end
      end
   endfunction

   function automatic void model_update();
      if (m_faulted) return;
      if (m_pending) begin
         if (mem_done) m_pending = 0;
         else begin
            m_age++;
            if (m_age >= TO) begin m_pending = 0; m_faulted = 1; end
         end
      end else if (wants_access()) begin
         if (illegal()) m_faulted = 1;
         else if (!mem_busy && !mem_done) begin
            m_pending = 1; m_age = 0;
            m_addr = address; m_wdata = write_data; m_is_store = Mem_write;
         end
      end
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      model_outputs();
      chk("mem_rd",    DW'(mem_rd),  DW'(e_rd));
      chk("mem_wr",    DW'(mem_wr),  DW'(e_wr));
      chk("mem_addr",  mem_addr,     e_addr);
      chk("mem_wdata", mem_wdata,    e_wdata);
      chk("data_read", data_read,    e_data);
      chk("valid_o",   DW'(valid_o), DW'(e_valid));
      chk("stall_o",   DW'(stall_o), DW'(e_stall));
      chk("err_o",     DW'(err_o),   DW'(e_err));
   endtask

   task automatic drive(input logic v, input logic r, input logic w, input logic [DW-1:0] a,
                        input logic [DW-1:0] wd, input logic b, input logic d,
                        input logic [DW-1:0] rd);
      valid_i = v; Mem_read = r; Mem_write = w; address = a; write_data = wd;
      mem_busy = b; mem_done = d; mem_rdata = rd;
      #1;
      compare_all();
   endtask

   task automatic advance();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      drive(0, 0, 0, '0, '0, 0, 0, '0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      int faulted_cycles;
      int op;
      logic [DW-1:0] a;
      model_reset();
      @(negedge clk);
      drive(0, 0, 0, '0, '0, 0, 0, '0);
      @(negedge clk);
      rst = 1'b1;
      drive(0, 0, 0, '0, '0, 0, 0, 16'h1234);
      chk("idle_stall", DW'(stall_o), '0);
      advance();

      // Load hit
      drive(1, 1, 0, 16'h0010, 16'h0000, 0, 1, 16'hBEEF);
      chk("hit_rd", DW'(mem_rd), 16'd1);
      chk("hit_addr", mem_addr, 16'h0010);
      chk("hit_data", data_read, 16'hBEEF);
      chk("hit_valid", DW'(valid_o), 16'd1);
      advance();

      // Store completing on the third cycle; EX/MEM inputs ignored while waiting
      drive(1, 0, 1, 16'h0020, 16'h1234, 0, 0, 16'h0);
      chk("st0_wr", DW'(mem_wr), 16'd1);
      chk("st0_stall", DW'(stall_o), 16'd1);
      advance();
      drive(1, 1, 0, 16'h5554, 16'h9999, 1, 0, 16'hFFFF);
      chk("st1_wr", DW'(mem_wr), 16'd0);
      chk("st1_addr", mem_addr, 16'h0020);
      chk("st1_stall", DW'(stall_o), 16'd1);
      advance();
      drive(1, 1, 0, 16'h5554, 16'h9999, 0, 1, 16'hFFFF);
      chk("st2_stall", DW'(stall_o), 16'd0);
      chk("st2_data", data_read, 16'h0000);
      chk("st2_wdata", mem_wdata, 16'h1234);
      advance();

      // Busy memory: retry until accepted
      for (int i = 0; i < 2; i++) begin
         drive(1, 1, 0, 16'h0030, 16'h0, 1, 0, 16'h0);
         chk("busy_rd", DW'(mem_rd), 16'd0);
         chk("busy_stall", DW'(stall_o), 16'd1);
         advance();
      end
      drive(1, 1, 0, 16'h0030, 16'h0, 0, 1, 16'h0A0A);
      chk("busy_go_rd", DW'(mem_rd), 16'd1);
      advance();

      // Misaligned, then conflicting read+write
      for (int k = 0; k < 2; k++) begin
         if (k == 0) drive(1, 1, 0, 16'h0011, 16'h0, 0, 1, 16'h0);
         else        drive(1, 1, 1, 16'h0010, 16'h0, 0, 1, 16'h0);
         chk("bad_rd", DW'(mem_rd), 16'd0);
         chk("bad_err0", DW'(err_o), 16'd0);
         advance();
         for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 16'h0010, 16'h0, 0, 1, 16'h7777);
            chk("bad_err", DW'(err_o), 16'd1);
            chk("bad_stall", DW'(stall_o), 16'd1);
            chk("bad_rd_err", DW'(mem_rd), 16'd0);
            advance();
         end
         do_reset();
      end

      // Timeout: issue cycle plus TO waiting cycles, then error; late done ignored
      drive(1, 1, 0, 16'h0040, 16'h0, 0, 0, 16'h0);
      advance();
      for (int i = 0; i < int'(TO); i++) begin
         drive(0, 0, 0, '0, '0, 0, 0, 16'h0);
         chk("to_wait_err", DW'(err_o), 16'd0);
         chk("to_wait_addr", mem_addr, 16'h0040);
         advance();
      end
      drive(0, 0, 0, '0, '0, 0, 1, 16'hAAAA);
      chk("to_err", DW'(err_o), 16'd1);
      chk("to_late_data", data_read, 16'h0000);
      chk("to_late_valid", DW'(valid_o), 16'd0);
      advance();
      do_reset();

      // Asynchronous reset in the middle of a wait
      drive(1, 0, 1, 16'h0080, 16'h5A5A, 0, 0, 16'h0);
      advance();
      drive(0, 0, 0, '0, '0, 0, 0, '0);
      chk("ar_pre_stall", DW'(stall_o), 16'd1);
      #2 rst = 1'b0;
      #1;
      chk("ar_stall", DW'(stall_o), 16'd0);
      chk("ar_addr", mem_addr, 16'h0000);
      chk("ar_wdata", mem_wdata, 16'h0000);
      chk("ar_err", DW'(err_o), 16'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      drive(0, 0, 0, '0, '0, 0, 1, 16'h1111);
      chk("ar_post_valid", DW'(valid_o), 16'd0);
      advance();

      // Random traffic
      faulted_cycles = 0;
      for (int c = 0; c < 3000; c++) begin
         op = int'($urandom_range(0, 9));
         a  = DW'($urandom) & 16'hFFFE;
         if ($urandom_range(0, 11) == 0) a[0] = 1'b1;
         drive(($urandom_range(0, 7) != 0),
               (op <= 3) || (op == 7),
               (op >= 4) && (op <= 7),
               a, DW'($urandom),
               ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 4) < 2),
               DW'($urandom));
         advance();
         if (m_faulted) faulted_cycles++;
         if (faulted_cycles >= 3) begin
            faulted_cycles = 0;
            do_reset();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
